actor_link_fifo: RTL and testbench
==================================

# actor_link_fifo

Token FIFO joining one actor output port (SEND/ACK/RDY/COUNT/DATA) to one actor input port (SEND/ACK/COUNT/DATA) in the dataflow network. It is the write-side and read-side counterpart of the port handshake generated for actors: it responds to a producer's SEND with ACK and RDY, and it presents tokens to a consumer as SEND/DATA/COUNT until the consumer returns ACK. It is instantiated once per network connection, between producer and consumer actors.

## Interface
Parameters:
- WIDTH, 16, token data width
- DEPTH, 8, token capacity; power of two, 2..256
- ADDR_W, 3, log2(DEPTH)

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  reset RESET, asynchronous, active-high; clock CLK
- WR_SEND  in  1  producer offers one token this cycle
- WR_DATA  in  WIDTH  producer token
- WR_COUNT  in  16  producer token count; only 1 is legal
- WR_ACK  out  1  token accepted this cycle
- WR_RDY  out  1  space available; producer may send
- RD_SEND  out  1  token available at RD_DATA
- RD_DATA  out  WIDTH  head token
- RD_COUNT  out  16  tokens held, zero-extended occupancy
- RD_ACK  in  1  consumer takes head token this cycle
- ERR  out  1  sticky protocol-error flag (see Configuration)

## Operation
- Storage: DEPTH x WIDTH array; write pointer wp, read pointer rp (ADDR_W bits, wrap modulo DEPTH); occupancy occ (ADDR_W+1 bits, 0..DEPTH).
- Write: accept = WR_SEND & WR_RDY. WR_ACK = accept (combinational). On accept: mem[wp] <= WR_DATA, wp <= wp+1.
- WR_RDY = ~RESET & (occ != DEPTH), from registered occ only.
- WR_SEND while WR_RDY=0: ignored, WR_ACK=0, no state change; the producer holds the token.
- Read: RD_SEND = (occ != 0). RD_DATA = mem[rp] (combinational from array). RD_COUNT = occ. take = RD_ACK & RD_SEND; on take: rp <= rp+1.
- RD_ACK while RD_SEND=0: ignored.
- Occupancy: occ <= occ + accept - take; simultaneous accept and take leaves occ unchanged.
- WR_COUNT values other than 1 still transfer exactly one token.
- Tokens are delivered in order, without loss or duplication.

## Timing
- Reset (asynchronous): occ=0, wp=0, rp=0, ERR=0. Outputs while RESET high: WR_RDY=0, WR_ACK=0, RD_SEND=0, RD_COUNT=0. RD_DATA is don't-care while RD_SEND=0. Array contents are not reset.
- Reset mid-operation: all held tokens are discarded; WR_RDY rises in the first cycle after RESET falls.
- Write-to-read latency: a token accepted in cycle N gives RD_SEND=1 in cycle N+1, never in cycle N. There is no bypass.
- Full: occ=DEPTH sets WR_RDY=0, even if a take occurs in the same cycle; WR_RDY returns to 1 the cycle after the take.
- Empty: occ=0 sets RD_SEND=0, even if an accept occurs in the same cycle.
- Throughput: one accept and one take per cycle sustained when 0<occ<DEPTH.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.

## Configuration
- ACTOR_LINK_FIFO_CHECK_EN defined: ERR is set on the next edge after any of: WR_SEND & ~WR_RDY & ~RESET (overflow attempt); WR_SEND & WR_RDY & WR_COUNT!=1; RD_ACK & ~RD_SEND (underflow). ERR stays set until RESET.
- Macro undefined: ERR is tied to 0, no check logic is built, and the datapath is unchanged.

## Test plan
- Reset then idle: WR_RDY=1 and RD_SEND=0 one cycle after RESET falls; RD_COUNT=0.
- Write 0x1234 at cycle N with RD_ACK=0: WR_ACK=1 at N; RD_SEND=1, RD_DATA=0x1234, RD_COUNT=1 at N+1; RD_ACK at N+1 gives RD_SEND=0 at N+2.
- DEPTH=8, write 8 tokens 0x0001..0x0008 with no reads: WR_RDY=0 and RD_COUNT=8; a ninth WR_SEND gets WR_ACK=0 and occ stays 8. Then read all 8 tokens in order; RD_SEND=0 after the eighth take.
- Full FIFO with simultaneous WR_SEND and RD_ACK: write refused, occ=7 next cycle, WR_RDY=1. Then continuous write+read for 20 cycles: occ stays constant, data is in order across pointer wrap.
- Assert RESET with 5 tokens held: RD_SEND=0 and RD_COUNT=0 immediately (asynchronous); after RESET falls, the next written token 0xBEEF is the first one read.
- With ACTOR_LINK_FIFO_CHECK_EN: WR_COUNT=2 with WR_SEND sets ERR=1 next cycle and one token is stored; RD_ACK on an empty FIFO sets ERR; ERR clears only on RESET. Without the macro, the same stimulus leaves ERR=0.

Source files
------------

// File: rtl/actor_link_fifo.sv
// ============================================================================
// Module   : actor_link_fifo
// Purpose  : Token FIFO linking one actor output port to one actor input port.
//            Define ACTOR_LINK_FIFO_CHECK_EN to build the sticky ERR checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module actor_link_fifo #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WR_SEND,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic [15:0]      WR_COUNT,
  output logic             WR_ACK,
  output logic             WR_RDY,
  output logic             RD_SEND,
  output logic [WIDTH-1:0] RD_DATA,
  output logic [15:0]      RD_COUNT,
  input  logic             RD_ACK,
  output logic             ERR
);

  localparam logic [ADDR_W:0] OCC_FULL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic              w_accept;
  logic              w_take;
  logic              w_wr_rdy;
  logic              w_rd_send;

  // Flags come from registered occupancy only, so a same-cycle take never
  // opens space and a same-cycle accept never bypasses to the read side.
  assign w_wr_rdy  = ~RESET & (occ_q != OCC_FULL);
  assign w_rd_send = (occ_q != '0);
  assign w_accept  = WR_SEND & w_wr_rdy;
  assign w_take    = RD_ACK & w_rd_send;

  assign WR_ACK   = w_accept;
  assign WR_RDY   = w_wr_rdy;
  assign RD_SEND  = w_rd_send;
  assign RD_DATA  = mem_q[rp_q];
  assign RD_COUNT = 16'(occ_q);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    occ_d = occ_q;
    if (w_accept) begin
      wp_d = wp_q + ADDR_W'(1);
    end
    if (w_take) begin
      rp_d = rp_q + ADDR_W'(1);
    end
    case ({w_accept, w_take})
      2'b10:   occ_d = occ_q + (ADDR_W+1)'(1);
      2'b01:   occ_d = occ_q - (ADDR_W+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      mem_q[wp_q] <= WR_DATA;
    end
  end

`ifdef ACTOR_LINK_FIFO_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (WR_SEND & ~w_wr_rdy & ~RESET)
          | (w_accept & (WR_COUNT != 16'd1))
          | (RD_ACK & ~w_rd_send);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  // Count only matters to the checker; every send moves exactly one token.
  logic w_unused_count;
  assign w_unused_count = ^WR_COUNT;
  assign ERR = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_actor_link_fifo.sv
// ============================================================================
// Module   : tb_actor_link_fifo
// Purpose  : Self-checking bench for actor_link_fifo (vector table, directed
//            corner sequences and random traffic against a queue model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_actor_link_fifo;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
`ifdef ACTOR_LINK_FIFO_CHECK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET;
  logic             WR_SEND;
  logic [WIDTH-1:0] WR_DATA;
  logic [15:0]      WR_COUNT;
  logic             WR_ACK;
  logic             WR_RDY;
  logic             RD_SEND;
  logic [WIDTH-1:0] RD_DATA;
  logic [15:0]      RD_COUNT;
  logic             RD_ACK;
  logic             ERR;

  actor_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .WR_SEND  (WR_SEND),
    .WR_DATA  (WR_DATA),
    .WR_COUNT (WR_COUNT),
    .WR_ACK   (WR_ACK),
    .WR_RDY   (WR_RDY),
    .RD_SEND  (RD_SEND),
    .RD_DATA  (RD_DATA),
    .RD_COUNT (RD_COUNT),
    .RD_ACK   (RD_ACK),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] model_q[$];
  logic             exp_err;

  typedef struct {
    logic        ws;
    logic [15:0] d;
    logic [15:0] c;
    logic        ra;
    logic        e_ack;
    logic        e_rdy;
    logic        e_send;
    logic [15:0] e_data;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ws, input logic [15:0] d, input logic [15:0] c, input logic ra);
    WR_SEND  = ws;
    WR_DATA  = d;
    WR_COUNT = c;
    RD_ACK   = ra;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 16'h0, 16'd1, 1'b0);
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    model_q.delete();
    exp_err = 1'b0;
    #1;
  endtask

  // One cycle of traffic: outputs are predicted from the token queue, checked
  // mid-cycle, then the queue is advanced by the spec's accept/take rules.
  task automatic mstep(input logic ws, input logic [15:0] d, input logic [15:0] c, input logic ra);
    logic e_rdy, e_send, e_ack, e_take;
    set_in(ws, d, c, ra);
    #2;
    e_rdy  = (model_q.size() != DEPTH);
    e_send = (model_q.size() != 0);
    e_ack  = ws && e_rdy;
    e_take = ra && e_send;
    chk("wr_ack",   {31'd0, WR_ACK},  {31'd0, e_ack});
    chk("wr_rdy",   {31'd0, WR_RDY},  {31'd0, e_rdy});
    chk("rd_send",  {31'd0, RD_SEND}, {31'd0, e_send});
    chk("rd_count", {16'd0, RD_COUNT}, 32'(model_q.size()));
    if (e_send) chk("rd_data", {16'd0, RD_DATA}, {16'd0, model_q[0]});
    chk("err", {31'd0, ERR}, {31'd0, exp_err});
    tick();
    if (CHK_ON && ((ws && !e_rdy) || (e_ack && c != 16'd1) || (ra && !e_send))) exp_err = 1'b1;
    if (e_take) void'(model_q.pop_front());
    if (e_ack) model_q.push_back(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pw_hi, pr_hi;
    int   pw, pr;

    //          ws    data      cnt  ra    ack   rdy   send  data      cnt
    tbl[0] = '{1'b0, 16'h0000, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0};
    tbl[1] = '{1'b1, 16'h1234, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0};
    tbl[2] = '{1'b0, 16'h0000, 16'd1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 16'd1};
    tbl[3] = '{1'b0, 16'h0000, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0};
    tbl[4] = '{1'b1, 16'h00AA, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0};
    tbl[5] = '{1'b1, 16'h00BB, 16'd1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00AA, 16'd1};
    tbl[6] = '{1'b0, 16'h0000, 16'd1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00BB, 16'd1};
    tbl[7] = '{1'b0, 16'h0000, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0};

    exp_err = 1'b0;
    set_in(1'b1, 16'h5555, 16'd1, 1'b1);
    RESET = 1'b1;
    #3;
    chk("reset_wr_rdy",   {31'd0, WR_RDY},   32'd0);
    chk("reset_wr_ack",   {31'd0, WR_ACK},   32'd0);
    chk("reset_rd_send",  {31'd0, RD_SEND},  32'd0);
    chk("reset_rd_count", {16'd0, RD_COUNT}, 32'd0);
    chk("reset_err",      {31'd0, ERR},      32'd0);
    do_reset();
    tick();
    chk("idle_wr_rdy",   {31'd0, WR_RDY},   32'd1);
    chk("idle_rd_send",  {31'd0, RD_SEND},  32'd0);
    chk("idle_rd_count", {16'd0, RD_COUNT}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].ws, tbl[i].d, tbl[i].c, tbl[i].ra);
      #2;
      chk($sformatf("vec%0d_wr_ack", i),  {31'd0, WR_ACK},   {31'd0, tbl[i].e_ack});
      chk($sformatf("vec%0d_wr_rdy", i),  {31'd0, WR_RDY},   {31'd0, tbl[i].e_rdy});
      chk($sformatf("vec%0d_rd_send", i), {31'd0, RD_SEND},  {31'd0, tbl[i].e_send});
      chk($sformatf("vec%0d_rd_cnt", i),  {16'd0, RD_COUNT}, {16'd0, tbl[i].e_cnt});
      if (tbl[i].e_send) chk($sformatf("vec%0d_rd_data", i), {16'd0, RD_DATA}, {16'd0, tbl[i].e_data});
      tick();
    end

    // Fill to capacity, refuse a ninth token, drain in order.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) mstep(1'b1, 16'(i), 16'd1, 1'b0);
    set_in(1'b0, 16'h0, 16'd1, 1'b0);
    #2;
    chk("full_wr_rdy",   {31'd0, WR_RDY},   32'd0);
    chk("full_rd_count", {16'd0, RD_COUNT}, 32'd8);
    mstep(1'b1, 16'h0009, 16'd1, 1'b0);
    chk("ninth_rd_count", {16'd0, RD_COUNT}, 32'd8);
    for (int i = 1; i <= DEPTH; i++) begin
      set_in(1'b0, 16'h0, 16'd1, 1'b1);
      #2;
      chk("drain_order", {16'd0, RD_DATA}, 32'(i));
      mstep(1'b0, 16'h0, 16'd1, 1'b1);
    end
    chk("drained_rd_send", {31'd0, RD_SEND}, 32'd0);

    // Full with simultaneous send and take, then sustained streaming across wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) mstep(1'b1, 16'h0A00 + 16'(i), 16'd1, 1'b0);
    mstep(1'b1, 16'h0099, 16'd1, 1'b1);
    set_in(1'b0, 16'h0, 16'd1, 1'b0);
    #2;
    chk("full_take_count", {16'd0, RD_COUNT}, 32'd7);
    chk("full_take_rdy",   {31'd0, WR_RDY},   32'd1);
    for (int i = 0; i < 20; i++) begin
      mstep(1'b1, 16'h0B00 + 16'(i), 16'd1, 1'b1);
      chk("stream_count", {16'd0, RD_COUNT}, 32'd7);
    end
    while (model_q.size() != 0) mstep(1'b0, 16'h0, 16'd1, 1'b1);

    // Asynchronous reset with five tokens held.
    do_reset();
    for (int i = 0; i < 5; i++) mstep(1'b1, 16'h0C00 + 16'(i), 16'd1, 1'b0);
    set_in(1'b1, 16'h7777, 16'd1, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rd_send",  {31'd0, RD_SEND},  32'd0);
    chk("async_rd_count", {16'd0, RD_COUNT}, 32'd0);
    chk("async_wr_ack",   {31'd0, WR_ACK},   32'd0);
    tick();
    set_in(1'b0, 16'h0, 16'd1, 1'b0);
    RESET = 1'b0;
    model_q.delete();
    exp_err = 1'b0;
    #1;
    chk("post_reset_rdy", {31'd0, WR_RDY}, 32'd1);
    mstep(1'b1, 16'hBEEF, 16'd1, 1'b0);
    set_in(1'b0, 16'h0, 16'd1, 1'b0);
    #2;
    chk("post_reset_first", {16'd0, RD_DATA}, 32'h0000BEEF);
    mstep(1'b0, 16'h0, 16'd1, 1'b1);

    // Protocol errors: bad count, underflow, stickiness.
    do_reset();
    mstep(1'b1, 16'h0C0C, 16'd2, 1'b0);
    chk("count2_err",    {31'd0, ERR},      {31'd0, CHK_ON});
    chk("count2_stored", {16'd0, RD_COUNT}, 32'd1);
    do_reset();
    mstep(1'b0, 16'h0, 16'd1, 1'b1);
    chk("underflow_err", {31'd0, ERR}, {31'd0, CHK_ON});
    for (int i = 0; i < 3; i++) mstep(1'b0, 16'h0, 16'd1, 1'b0);
    chk("err_sticky", {31'd0, ERR}, {31'd0, CHK_ON});
    do_reset();
    chk("err_cleared", {31'd0, ERR}, 32'd0);

    // Random traffic with shifting write/read pressure.
    for (int blk = 0; blk < 8; blk++) begin
      pw_hi = blk[0];
      pr_hi = blk[1] ^ blk[2];
      pw = pw_hi ? 8 : 3;
      pr = pr_hi ? 8 : 3;
      for (int i = 0; i < 50; i++) begin
        mstep(($urandom_range(0, 9) < pw) ? 1'b1 : 1'b0,
              16'($urandom),
              ($urandom_range(0, 15) == 0) ? 16'($urandom_range(0, 3)) : 16'd1,
              ($urandom_range(0, 9) < pr) ? 1'b1 : 1'b0);
      end
    end
    while (model_q.size() != 0) mstep(1'b0, 16'h0, 16'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
